// File: rtl/cpu_sequencer_pkg.sv
// Shared constants for the CPU sequencer: FSM states, reset/interrupt
// addresses and the opcode values the decoder recognises.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_IRQ   = 3'd4
  } state_e;

  localparam logic [7:0] DEF_RESET_PC   = 8'h00;
  localparam logic [7:0] DEF_INT_VECTOR = 8'hF0;
  localparam int         DEF_CNT_WIDTH  = 16;

  // Opcode lives in ir[23:16]; operand byte in ir[7:0].
  localparam logic [7:0] OP_NOP = 8'h01;
  localparam logic [7:0] OP_JMR = 8'h02;
  localparam logic [7:0] OP_RTN = 8'h03;

  // Sequential PC advance; 8-bit arithmetic wraps FF -> 00.
  function automatic logic [7:0] pc_inc(input logic [7:0] p);
    return p + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// ROM fetch and decoder bus between the sequencer and the datapath.
interface cpu_sequencer_if;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [23:0] ir;
  logic [7:0]  pc;
  logic        commit;
  logic        dec_jump_enable;
  logic [7:0]  dec_jump_data;
  logic        dec_is_rtn;

  modport master (
    output rom_addr, ir, pc, commit,
    input  rom_data, dec_jump_enable, dec_jump_data, dec_is_rtn
  );

  modport slave (
    input  rom_addr, ir, pc, commit,
    output rom_data, dec_jump_enable, dec_jump_data, dec_is_rtn
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: owns PC/IR, fetches from synchronous ROM,
// issues one commit strobe per instruction, handles run/step debug
// control, a single non-nesting interrupt and a retired-instruction count.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [7:0] INT_VECTOR = DEF_INT_VECTOR,
  parameter int         CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step_req,
  cpu_sequencer_if.master      bus,
  input  logic                 irq,
  output logic                 irq_ack,
  output logic                 irq_push,
  output logic [7:0]           irq_push_data,
  output logic                 in_isr,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instret
);

  state_e               state_q, state_d;
  logic [7:0]           pc_q, pc_d;
  logic [23:0]          ir_q, ir_d;
  logic                 in_isr_q, in_isr_d;
  logic                 step_q, step_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALT;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      in_isr_q  <= 1'b0;
      step_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      in_isr_q  <= in_isr_d;
      step_q    <= step_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    in_isr_d      = in_isr_q;
    step_d        = step_q;
    instret_d     = instret_q;
    bus.commit    = 1'b0;
    irq_ack       = 1'b0;
    irq_push      = 1'b0;
    irq_push_data = pc_q;
    halted        = 1'b0;
    bus.rom_addr  = pc_q;
    case (state_q)
      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_d = ST_FETCH;
        end else if (step_req) begin
          state_d = ST_FETCH;
          step_d  = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        ir_d    = bus.rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        bus.commit = 1'b1;
        pc_d       = bus.dec_jump_enable ? bus.dec_jump_data : pc_inc(pc_q);
        instret_d  = instret_q + 1'b1;
        step_d     = 1'b0;
        if (bus.dec_is_rtn && in_isr_q) in_isr_d = 1'b0;
        // Boundary decision: step, halt, interrupt, continue.
        if (step_q)                state_d = ST_HALT;
        else if (!run)             state_d = ST_HALT;
        else if (irq && !in_isr_d) state_d = ST_IRQ;
        else                       state_d = ST_FETCH;
      end
      ST_IRQ: begin
        irq_push = 1'b1;
        irq_ack  = 1'b1;
        in_isr_d = 1'b1;
        pc_d     = INT_VECTOR;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign bus.ir  = ir_q;
  assign bus.pc  = pc_q;
  assign in_isr  = in_isr_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: ROM and a tiny decoder/stack live here; a
// cycle table, directed corner cases and an instruction-level random model.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, step_req, irq;
  logic        irq_ack, irq_push, in_isr, halted;
  logic [7:0]  irq_push_data;
  logic [15:0] instret;

  cpu_sequencer_if sif ();

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req), .bus(sif),
    .irq(irq), .irq_ack(irq_ack), .irq_push(irq_push),
    .irq_push_data(irq_push_data), .in_isr(in_isr), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Synchronous ROM.
  logic [23:0] rom [256];
  always @(posedge clk) sif.rom_data <= rom[sif.rom_addr];

  // Return-address stack fed by irq_push, popped by a committing RTN.
  logic [7:0] stk [16];
  int         sp;
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (irq_push) begin
      stk[sp] <= irq_push_data;
      sp      <= sp + 1;
    end else if (sif.commit && sif.dec_is_rtn && sp > 0) sp <= sp - 1;
  end

  // Decoder: JMR jumps to operand, RTN jumps to stack top.
  always_comb begin
    int top;
    top = (sp > 0) ? sp - 1 : 0;
    sif.dec_jump_enable = 1'b0;
    sif.dec_jump_data   = 8'h00;
    sif.dec_is_rtn      = 1'b0;
    if (sif.ir[23:16] == OP_JMR) begin
      sif.dec_jump_enable = 1'b1;
      sif.dec_jump_data   = sif.ir[7:0];
    end else if (sif.ir[23:16] == OP_RTN) begin
      sif.dec_is_rtn      = 1'b1;
      sif.dec_jump_enable = (sp > 0);
      sif.dec_jump_data   = stk[top];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] nop();
    return {OP_NOP, 16'hA5A5};
  endfunction

  function automatic logic [23:0] jmr(input logic [7:0] t);
    return {OP_JMR, 8'h3C, t};
  endfunction

  task automatic fill_nops();
    for (int i = 0; i < 256; i++) rom[i] = nop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step_req = 1'b0; irq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the next negedge showing commit, bounded.
  task automatic wait_commit(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!sif.commit && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, sif.commit, 1);
  endtask

  task automatic count_commits(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sif.commit) cnt++;
    end
  endtask

  typedef struct {
    logic       run;
    logic       halted;
    logic       commit;
    logic [7:0] rom_addr;
    int         instret;
  } vec_t;

  vec_t vec [17];

  initial begin
    int cnt, n;
    logic [7:0]  m_pc, m_ret, nxt;
    logic        m_isr, exp_ack;
    logic [15:0] m_instret;
    logic [23:0] inst;

    rst = 1'b1; run = 1'b0; step_req = 1'b0; irq = 1'b0;
    // run, halted, commit, rom_addr, instret (next cycle)
    vec[0]  = '{1, 0, 0, 8'h00, 0};
    vec[1]  = '{1, 0, 0, 8'h00, 0};
    vec[2]  = '{1, 0, 1, 8'h00, 0};
    vec[3]  = '{1, 0, 0, 8'h01, 1};
    vec[4]  = '{1, 0, 0, 8'h01, 1};
    vec[5]  = '{1, 0, 1, 8'h01, 1};
    vec[6]  = '{1, 0, 0, 8'h02, 2};
    vec[7]  = '{1, 0, 0, 8'h02, 2};
    vec[8]  = '{1, 0, 1, 8'h02, 2};
    vec[9]  = '{1, 0, 0, 8'h03, 3};
    vec[10] = '{1, 0, 0, 8'h03, 3};
    vec[11] = '{1, 0, 1, 8'h03, 3};
    vec[12] = '{1, 0, 0, 8'h04, 4};
    vec[13] = '{0, 0, 0, 8'h04, 4};
    vec[14] = '{0, 0, 1, 8'h04, 4};
    vec[15] = '{0, 1, 0, 8'h05, 5};
    vec[16] = '{0, 1, 0, 8'h05, 5};
    fill_nops();

    // Reset state.
    do_reset();
    chk("rst_halted", halted, 1);
    chk("rst_rom_addr", sif.rom_addr, 8'h00);
    chk("rst_pc", sif.pc, 8'h00);
    chk("rst_ir", sif.ir, 0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_instret", instret, 0);
    chk("rst_commit", sif.commit, 0);
    chk("rst_irq_ack", irq_ack, 0);
    chk("rst_irq_push", irq_push, 0);

    // Cycle table: free-running NOPs, then halt at the boundary.
    for (int i = 0; i < 17; i++) begin
      run = vec[i].run;
      @(negedge clk);
      chk($sformatf("tbl%0d_halted", i), halted, vec[i].halted);
      chk($sformatf("tbl%0d_commit", i), sif.commit, vec[i].commit);
      chk($sformatf("tbl%0d_rom_addr", i), sif.rom_addr, vec[i].rom_addr);
      chk($sformatf("tbl%0d_instret", i), instret, vec[i].instret);
    end

    // JMR 0x40 at 0x00.
    do_reset();
    rom[0] = jmr(8'h40);
    run = 1'b1;
    wait_commit("jmr_commit");
    @(negedge clk);
    chk("jmr_rom_addr", sif.rom_addr, 8'h40);
    chk("jmr_pc", sif.pc, 8'h40);

    // Wrap FF -> 00.
    do_reset();
    rom[0] = jmr(8'hFF);
    run = 1'b1;
    wait_commit("wrap_c1");
    wait_commit("wrap_c2");
    chk("wrap_pc_ff", sif.pc, 8'hFF);
    @(negedge clk);
    chk("wrap_rom_addr", sif.rom_addr, 8'h00);
    rom[0] = nop();

    // Interrupt entry, no nesting, retake after RTN.
    do_reset();
    rom[8'hF1] = {OP_RTN, 16'h0000};
    run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.commit && sif.pc == 8'h05) && n < 100);
    chk("irq_exec5_pc", sif.pc, 8'h05);
    irq = 1'b1;
    @(negedge clk);
    chk("irq_ack", irq_ack, 1);
    chk("irq_push", irq_push, 1);
    chk("irq_push_data", irq_push_data, 8'h06);
    @(negedge clk);
    chk("irq_vec_addr", sif.rom_addr, 8'hF0);
    chk("irq_in_isr", in_isr, 1);
    wait_commit("isr_nop_commit");
    @(negedge clk);
    chk("irq_nest_blocked", irq_ack, 0);
    chk("isr_next_addr", sif.rom_addr, 8'hF1);
    wait_commit("rtn_commit");
    chk("rtn_pc", sif.pc, 8'hF1);
    @(negedge clk);
    chk("irq_retake_ack", irq_ack, 1);
    chk("irq_retake_data", irq_push_data, 8'h06);
    chk("irq_retake_isr", in_isr, 0);
    irq = 1'b0;
    @(negedge clk);
    chk("irq_retake_vec", sif.rom_addr, 8'hF0);
    rom[8'hF1] = nop();

    // Single step, then a step_req during FETCH is ignored.
    do_reset();
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    count_commits(8, cnt);
    chk("step1_commits", cnt, 1);
    chk("step1_halted", halted, 1);
    chk("step1_pc", sif.pc, 8'h01);
    step_req = 1'b1;
    @(negedge clk);
    chk("step2_fetch", halted, 0);
    @(negedge clk);
    step_req = 1'b0;
    count_commits(10, cnt);
    chk("step2_commits", cnt, 1);
    chk("step2_pc", sif.pc, 8'h02);

    // Reset during LOAD aborts the instruction.
    do_reset();
    rom[2] = {OP_NOP, 16'h1234};
    run = 1'b1;
    wait_commit("rl_c1");
    wait_commit("rl_c2");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rl_halted", halted, 1);
    chk("rl_pc", sif.pc, 8'h00);
    chk("rl_ir", sif.ir, 0);
    chk("rl_instret", instret, 0);
    chk("rl_commit", sif.commit, 0);
    count_commits(6, cnt);
    chk("rl_no_commit", cnt, 0);
    rom[2] = nop();

    // Random run/irq against an instruction-level model.
    do_reset();
    for (int i = 0; i < 64; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? jmr(8'($urandom_range(0, 63)))
                                           : {OP_NOP, 16'($urandom)};
    rom[63]    = jmr(8'h00);
    rom[8'hF0] = nop();
    rom[8'hF1] = {OP_RTN, 16'h0000};
    m_pc = 8'h00; m_ret = 8'h00; m_isr = 1'b0; m_instret = '0; exp_ack = 1'b0;
    run = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      chk("rand_irq_ack", irq_ack, exp_ack);
      exp_ack = 1'b0;
      run = ($urandom_range(0, 9) != 0);
      irq = ($urandom_range(0, 5) == 0);
      if (sif.commit) begin
        chk("rand_pc", sif.pc, m_pc);
        chk("rand_ir", sif.ir, rom[m_pc]);
        chk("rand_instret", instret, m_instret);
        inst = rom[m_pc];
        if (inst[23:16] == OP_JMR) nxt = inst[7:0];
        else if (inst[23:16] == OP_RTN && m_isr) nxt = m_ret;
        else nxt = m_pc + 8'd1;
        if (inst[23:16] == OP_RTN) m_isr = 1'b0;
        m_instret = m_instret + 16'd1;
        if (run && irq && !m_isr) begin
          m_ret   = nxt;
          m_pc    = 8'hF0;
          m_isr   = 1'b1;
          exp_ack = 1'b1;
        end else m_pc = nxt;
      end
    end
    chk("rand_progress", 32'(m_instret > 16'd300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
